// File: rtl/bsg_arb_aging_pkg.sv
// Shared types for the aging round-robin arbiter.
package bsg_arb_aging_pkg;

  typedef enum logic [1:0] {
    eIdle,
    eHold,
    eLock
  } arb_state_e;

endpackage

// File: rtl/bsg_age_counter_async.sv
// Saturating wait counter: clear has priority and yields 0, otherwise count up to age_max_p.
module bsg_age_counter_async #(
  parameter int age_max_p = 15,
  parameter int width_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               inc_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != width_p'(age_max_p))) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_arb_aging_rr.sv
// Round-robin arbiter with per-requester aging: saturated waiters win first,
// an unconsumed grant is held, and a consumer may lock the resource to its winner.
module bsg_arb_aging_rr
  import bsg_arb_aging_pkg::*;
#(
  parameter  int els_p        = 4,
  parameter  int age_max_p    = 15,
  localparam int id_width_lp  = (els_p == 1) ? 1 : $clog2(els_p),
  localparam int age_width_lp = ((age_max_p + 1) == 1) ? 1 : $clog2(age_max_p + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [els_p-1:0]              req_i,
  input  logic                          yumi_i,
  input  logic                          lock_i,
  output logic                          v_o,
  output logic [els_p-1:0]              grant_o,
  output logic [id_width_lp-1:0]        grant_id_o,
  output logic [els_p*age_width_lp-1:0] age_o
);

  // Returns {found, index} of the first set bit at or after ptr, wrapping modulo els_p.
  function automatic logic [id_width_lp:0] rr_pick(input logic [els_p-1:0]       vec,
                                                   input logic [id_width_lp-1:0] ptr);
    logic [id_width_lp:0] res;
    int j;
    res = '0;
    for (int k = els_p - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= els_p) j = j - els_p;
      if (vec[j]) res = {1'b1, id_width_lp'(j)};
    end
    return res;
  endfunction

  arb_state_e               state_q, state_d;
  logic [id_width_lp-1:0]   rr_ptr_q, rr_ptr_d;
  logic [id_width_lp-1:0]   held_id_q, held_id_d;
  logic [id_width_lp-1:0]   owner_q, owner_d;

  logic [els_p-1:0][age_width_lp-1:0] age;
  logic [els_p-1:0]         sat_vec;
  logic [id_width_lp:0]     sat_pick, req_pick;
  logic [id_width_lp-1:0]   fresh_id, sel_id;
  logic                     v, yumi_ok;

  always_comb begin
    sat_vec = '0;
    for (int i = 0; i < els_p; i++) begin
      sat_vec[i] = req_i[i] && (age[i] == age_width_lp'(age_max_p));
    end
  end

  assign sat_pick = rr_pick(sat_vec, rr_ptr_q);
  assign req_pick = rr_pick(req_i, rr_ptr_q);
  assign fresh_id = sat_pick[id_width_lp] ? sat_pick[id_width_lp-1:0] : req_pick[id_width_lp-1:0];

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    held_id_d = held_id_q;
    owner_d   = owner_q;
    v         = |req_i;
    sel_id    = fresh_id;

    case (state_q)
      eHold:   if (req_i[held_id_q]) sel_id = held_id_q;
      eLock:   begin
        v      = req_i[owner_q];
        sel_id = owner_q;
      end
      default: ;
    endcase

    // A yumi without an offered grant must leave all state untouched.
    yumi_ok = yumi_i && v;

    if (yumi_ok) begin
      rr_ptr_d = (sel_id == id_width_lp'(els_p - 1)) ? '0 : sel_id + 1'b1;
    end

    if (state_q == eLock) begin
      if (!v || (yumi_ok && !lock_i)) state_d = eIdle;
    end else if (v) begin
      if (yumi_ok) begin
        state_d = lock_i ? eLock : eIdle;
        if (lock_i) owner_d = sel_id;
      end else begin
        state_d   = eHold;
        held_id_d = sel_id;
      end
    end else begin
      state_d = eIdle;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= eIdle;
      rr_ptr_q  <= '0;
      held_id_q <= '0;
      owner_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      held_id_q <= held_id_d;
      owner_q   <= owner_d;
    end
  end

  assign v_o        = v;
  assign grant_id_o = v ? sel_id : '0;
  assign grant_o    = v ? ({{(els_p-1){1'b0}}, 1'b1} << sel_id) : '0;

  for (genvar i = 0; i < els_p; i++) begin : g_age
    bsg_age_counter_async #(
      .age_max_p(age_max_p),
      .width_p  (age_width_lp)
    ) u_age (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .clear_i  (grant_o[i] && yumi_ok),
      .inc_i    (req_i[i]),
      .count_o  (age[i])
    );
    assign age_o[i*age_width_lp +: age_width_lp] = age[i];
  end

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_arb_aging_rr.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_bsg_arb_aging_rr;

  typedef struct {
    int          sel;
    logic        v;
    int          id;
    logic [15:0] ages;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_pop  = 0;

  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b0;

  logic [3:0]  req_a  = '0;
  logic        yumi_a = 1'b0, lock_a = 1'b0;
  logic        v_a;
  logic [3:0]  grant_a;
  logic [1:0]  gid_a;
  logic [7:0]  age_a;

  logic [2:0]  req_b  = '0;
  logic        yumi_b = 1'b0, lock_b = 1'b0;
  logic        v_b;
  logic [2:0]  grant_b;
  logic [1:0]  gid_b;
  logic [11:0] age_b;

  always #5 clk_i = ~clk_i;

  bsg_arb_aging_rr #(.els_p(4), .age_max_p(3)) dut_a (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .req_i(req_a), .yumi_i(yumi_a), .lock_i(lock_a),
    .v_o(v_a), .grant_o(grant_a), .grant_id_o(gid_a), .age_o(age_a)
  );

  bsg_arb_aging_rr #(.els_p(3), .age_max_p(15)) dut_b (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .req_i(req_b), .yumi_i(yumi_b), .lock_i(lock_b),
    .v_o(v_b), .grant_o(grant_b), .grant_id_o(gid_b), .age_o(age_b)
  );

  function automatic logic [15:0] pa(int a3, int a2, int a1, int a0);
    return {8'd0, 2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  function automatic logic [15:0] pb(int a2, int a1, int a0);
    return {4'd0, 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; rst pulses reset_n_i low within the cycle, away from both edges.
  task automatic step(int sel, logic [3:0] req, logic yumi, logic lock,
                      logic ev, int eid, logic [15:0] eages, logic rst);
    exp_t e;
    @(posedge clk_i);
    #1;
    if (sel == 0) begin
      req_a = req; yumi_a = yumi; lock_a = lock;
    end else begin
      req_b = req[2:0]; yumi_b = yumi; lock_b = lock;
    end
    if (rst) reset_n_i = 1'b0;
    e.sel = sel; e.v = ev; e.id = eid; e.ages = eages;
    sb_q.push_back(e);
    if (rst) begin
      @(negedge clk_i);
      #1;
      reset_n_i = 1'b1;
    end
  endtask

  always @(negedge clk_i) begin
    exp_t        e;
    logic [15:0] eg;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_pop++;
      eg = e.v ? (16'd1 << e.id) : 16'd0;
      if (e.sel == 0) begin
        check($sformatf("a#%0d v_o", n_pop),        16'(v_a),     16'(e.v));
        check($sformatf("a#%0d grant_id_o", n_pop), 16'(gid_a),   16'(e.id));
        check($sformatf("a#%0d grant_o", n_pop),    16'(grant_a), eg);
        check($sformatf("a#%0d age_o", n_pop),      16'(age_a),   e.ages);
      end else begin
        check($sformatf("b#%0d v_o", n_pop),        16'(v_b),     16'(e.v));
        check($sformatf("b#%0d grant_id_o", n_pop), 16'(gid_b),   16'(e.id));
        check($sformatf("b#%0d grant_o", n_pop),    16'(grant_b), eg);
        check($sformatf("b#%0d age_o", n_pop),      16'(age_b),   e.ages);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // reset state
    step(0, 4'b0000, 0, 0, 0, 0, pa(0,0,0,0), 0);
    // plain round robin between 1 and 3
    step(0, 4'b1010, 1, 0, 1, 1, pa(0,0,0,0), 0);
    step(0, 4'b1010, 1, 0, 1, 3, pa(1,0,0,0), 0);
    step(0, 4'b1010, 1, 0, 1, 1, pa(0,0,1,0), 0);
    step(0, 4'b1010, 1, 0, 1, 3, pa(1,0,0,0), 0);
    // withdrawn requester keeps its age
    step(0, 4'b0000, 0, 0, 0, 0, pa(0,0,1,0), 0);
    // lock on 3 while requester 1 ages to saturation
    step(0, 4'b1000, 1, 1, 1, 3, pa(0,0,1,0), 0);
    step(0, 4'b1010, 0, 0, 1, 3, pa(0,0,1,0), 0);
    step(0, 4'b1010, 0, 0, 1, 3, pa(1,0,2,0), 0);
    step(0, 4'b1010, 0, 0, 1, 3, pa(2,0,3,0), 0);
    step(0, 4'b1010, 1, 0, 1, 3, pa(3,0,3,0), 0);
    // saturated 1 beats rr_ptr=0
    step(0, 4'b0011, 0, 0, 1, 1, pa(0,0,3,0), 0);
    step(0, 4'b0011, 1, 0, 1, 1, pa(0,0,3,1), 0);
    step(0, 4'b0001, 1, 0, 1, 0, pa(0,0,0,2), 0);
    // hold on 1 regardless of ages and new requests
    step(0, 4'b0110, 0, 0, 1, 1, pa(0,0,0,0), 0);
    step(0, 4'b0110, 0, 0, 1, 1, pa(0,1,1,0), 0);
    step(0, 4'b0110, 0, 0, 1, 1, pa(0,2,2,0), 0);
    step(0, 4'b0110, 0, 0, 1, 1, pa(0,3,3,0), 0);
    step(0, 4'b0110, 0, 0, 1, 1, pa(0,3,3,0), 0);
    step(0, 4'b1110, 0, 0, 1, 1, pa(0,3,3,0), 0);
    step(0, 4'b1100, 0, 0, 1, 2, pa(1,3,3,0), 0);
    // lock on 2 against full contention, then release
    step(0, 4'b1100, 1, 1, 1, 2, pa(2,3,3,0), 0);
    step(0, 4'b1111, 0, 0, 1, 2, pa(3,0,3,0), 0);
    step(0, 4'b1111, 0, 0, 1, 2, pa(3,1,3,1), 0);
    step(0, 4'b1111, 0, 0, 1, 2, pa(3,2,3,2), 0);
    step(0, 4'b1111, 1, 0, 1, 2, pa(3,3,3,3), 0);
    step(0, 4'b1111, 1, 0, 1, 3, pa(3,0,3,3), 0);
    step(0, 4'b1111, 1, 0, 1, 0, pa(0,1,3,3), 0);
    // lock on 0, then reset mid-lock
    step(0, 4'b0001, 1, 1, 1, 0, pa(1,2,3,0), 0);
    step(0, 4'b0110, 0, 0, 1, 1, pa(0,0,0,0), 1);
    step(0, 4'b0110, 1, 0, 1, 1, pa(0,1,1,0), 0);
    // owner dropping request ends the lock with v_o=0 that cycle
    step(0, 4'b1000, 1, 1, 1, 3, pa(0,2,0,0), 0);
    step(0, 4'b0100, 0, 0, 0, 0, pa(0,2,0,0), 0);
    step(0, 4'b0100, 1, 0, 1, 2, pa(0,3,0,0), 0);
    step(0, 4'b0000, 0, 0, 0, 0, pa(0,0,0,0), 0);

    // three requesters: pointer wraps from 2 to 0, reset mid-lock
    step(1, 4'b0100, 1, 0, 1, 2, pb(0,0,0), 0);
    step(1, 4'b0101, 1, 0, 1, 0, pb(0,0,0), 0);
    step(1, 4'b0101, 1, 0, 1, 2, pb(1,0,0), 0);
    step(1, 4'b0011, 1, 1, 1, 0, pb(0,0,1), 0);
    step(1, 4'b0010, 0, 0, 1, 1, pb(0,0,0), 1);
    step(1, 4'b0010, 1, 0, 1, 1, pb(0,1,0), 0);
    step(1, 4'b0000, 0, 0, 0, 0, pb(0,0,0), 0);

    repeat (3) @(posedge clk_i);
    check("scoreboard drained", 16'(sb_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
